// File: rtl/fifo_rr_sched_pkg.sv
// fifo_rr_sched_pkg
//   Shared definitions for the round-robin FIFO drain scheduler:
//   - state_t : scheduler FSM state (IDLE = no grant, BUSY = grant held)
//   - legal ranges for the NQ and BURST parameters, with helper checks
package fifo_rr_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NQ_MIN    = 2;
  localparam int NQ_MAX    = 16;
  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 255;

  function automatic bit nq_ok(int nq);
    return (nq >= NQ_MIN) && (nq <= NQ_MAX);
  endfunction

  function automatic bit burst_ok(int burst);
    return (burst >= BURST_MIN) && (burst <= BURST_MAX);
  endfunction

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker. Returns the first asserted
//   request at or after ptr, wrapping modulo NQ.
//   Ports:
//     req   in  NQ    request vector (1 = candidate)
//     ptr   in  GWID  starting index of the search (always < NQ)
//     found out 1     at least one request is set
//     idx   out GWID  selected index (0 when found is low)
module rr_pick
  import fifo_rr_sched_pkg::*;
#(
  parameter int NQ   = 4,
  parameter int GWID = $clog2(NQ)
) (
  input  logic [NQ-1:0]   req,
  input  logic [GWID-1:0] ptr,
  output logic            found,
  output logic [GWID-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins; this keeps the loop free of early exits.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NQ;
      if (req[j]) begin
        found = 1'b1;
        idx   = GWID'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched
//   Drains NQ first-word-fall-through FIFOs into a single registered output
//   word, granting FIFOs round-robin with at most BURST consecutive reads per
//   grant. One IDLE cycle separates bursts.
//   Ports:
//     clk           in   1       rising-edge clock
//     rst_n         in   1       asynchronous active-low reset
//     softreset     in   1       synchronous clear, same effect as rst_n
//     empty         in   NQ      per-FIFO empty flags
//     fifo_data     in   NQ*WID  per-FIFO head word, FIFO i at [i*WID +: WID]
//     readout       out  NQ      per-FIFO pop strobe (one-hot or zero)
//     out_valid     out  1       output register holds a word
//     out_ready     in   1       consumer accepts the word
//     out_data      out  WID     registered word
//     out_src       out  GWID    FIFO index that supplied out_data
//     state_dbg     out  state_t FSM state
//     g_dbg         out  GWID    current grant register
//     rr_ptr_dbg    out  GWID    round-robin search start
//     burst_cnt_dbg out  BCW     reads done in the current burst
//
//   Handshake: a word moves from out_data to the consumer on every rising
//   edge where out_valid && out_ready. out_valid never drops without such a
//   transfer (except on reset), and out_data/out_src stay stable while
//   out_valid is high and out_ready is low. On the FIFO side, readout[i] high
//   at an edge pops FIFO i; it is only ever raised when empty[i] is low.
module fifo_rr_sched
  import fifo_rr_sched_pkg::*;
#(
  parameter int NQ    = 4,
  parameter int WID   = 32,
  parameter int BURST = 4,
  parameter int GWID  = $clog2(NQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   softreset,
  input  logic [NQ-1:0]          empty,
  input  logic [NQ*WID-1:0]      fifo_data,
  output logic [NQ-1:0]          readout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WID-1:0]         out_data,
  output logic [GWID-1:0]        out_src,
  output state_t                 state_dbg,
  output logic [GWID-1:0]        g_dbg,
  output logic [GWID-1:0]        rr_ptr_dbg,
  output logic [$clog2(BURST):0] burst_cnt_dbg
);

  // One spare bit so burst_cnt can reach BURST without wrapping.
  localparam int BCW = $clog2(BURST) + 1;

  if (!nq_ok(NQ)) begin : g_bad_nq
    $error("fifo_rr_sched: NQ out of range");
  end
  if (!burst_ok(BURST)) begin : g_bad_burst
    $error("fifo_rr_sched: BURST out of range");
  end

  state_t          state, state_nxt;
  logic [GWID-1:0] g, g_nxt;
  logic [GWID-1:0] rr_ptr, rr_ptr_nxt;
  logic [BCW-1:0]  burst_cnt, burst_cnt_nxt;

  logic            pick_found;
  logic [GWID-1:0] pick_idx;
  logic            space;
  logic            load;
  logic            grant_empty;
  logic            burst_last;

  logic [WID-1:0]  head [NQ];

  for (genvar i = 0; i < NQ; i++) begin : g_head
    assign head[i] = fifo_data[i*WID +: WID];
  end

  rr_pick #(
    .NQ   (NQ),
    .GWID (GWID)
  ) u_pick (
    .req   (~empty),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // softreset gates load so a clear in mid-burst never pops a word that the
  // same edge would then throw away.
  always_comb begin
    grant_empty = empty[g];
    space       = !out_valid || out_ready;
    load        = (state == BUSY) && space && !grant_empty && !softreset;
    burst_last  = (burst_cnt == BCW'(BURST - 1));
    readout     = '0;
    if (load) begin
      readout[g] = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          g_nxt         = pick_idx;
          burst_cnt_nxt = '0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (load) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        // A drained FIFO ends the burst even while back-pressured.
        if ((load && burst_last) || grant_empty) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (g == GWID'(NQ - 1)) ? '0 : g + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (softreset) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (softreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= head[g];
      out_src   <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign state_dbg     = state;
  assign g_dbg         = g;
  assign rr_ptr_dbg    = rr_ptr;
  assign burst_cnt_dbg = burst_cnt;

endmodule

// File: doc/fifo_rr_sched.md
FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

Interface
REQ-001 Parameter: NQ, default 4, number of upstream single-clock FIFOs drained (2..16).
REQ-002 Parameter: WID, default 32, data width per FIFO.
REQ-003 Parameter: BURST, default 4, maximum consecutive reads granted to one FIFO (1..255).
REQ-004 Parameter: GWID, default $clog2(NQ), grant index width.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 softreset  input  1  synchronous clear, same effect as reset.
REQ-008 empty  input  NQ  per-FIFO empty flags.
REQ-009 fifo_data  input  NQ*WID  per-FIFO head data, FIFO i at bits [i*WID +: WID], first-word-fall-through.
REQ-010 readout  output  NQ  per-FIFO pop strobe, at most one bit high (one-hot or zero).
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid && out_ready.
REQ-013 out_data  output  WID  registered word.
REQ-014 out_src  output  GWID  index of the FIFO that supplied out_data.

Function
REQ-015 FSM states: IDLE (no grant) and BUSY (grant register g valid).
REQ-016 IDLE: if any empty bit is low, select the first non-empty index at or after rr_ptr, wrapping modulo NQ; g <= selected, burst_cnt <= 0, go to BUSY; otherwise stay in IDLE.
REQ-017 space = !out_valid || out_ready; load = BUSY && space && !empty[g].
REQ-018 readout[g] = load, combinational; readout is all-zero in IDLE.
REQ-019 On load: out_data <= fifo_data slice g, out_src <= g, out_valid <= 1, burst_cnt <= burst_cnt+1.
REQ-020 out_valid falls to 0 when out_ready is high and load is low.
REQ-021 BUSY -> IDLE, with rr_ptr <= (g==NQ-1) ? 0 : g+1, on either condition: load with burst_cnt==BURST-1, or empty[g] high.
REQ-022 Back-pressure: a BUSY state with out_valid high and out_ready low holds g and burst_cnt, and keeps readout at zero.
REQ-023 Latency: empty[i] falls at edge t in IDLE, so g=i after t+1, and out_valid rises after t+2; sustained throughput is one word per cycle within a burst.
REQ-024 Rotation bubble: exactly one IDLE cycle between bursts, with no read in that cycle.
REQ-025 A FIFO that goes empty mid-burst ends the burst without a read in that cycle.
REQ-026 burst_cnt width is $clog2(BURST)+1 and it never wraps.
REQ-027 The block never asserts readout to a FIFO whose empty is high, so it cannot underflow.

Reset
REQ-028 rst_n low, or softreset high: state IDLE, g=0, rr_ptr=0, burst_cnt=0, out_valid=0, out_data=0, out_src=0, readout=0.
REQ-029 A reset in mid-burst discards the word held in the output register and issues no further readout.

Structure
REQ-030 A shared package holds the FSM state enum (IDLE, BUSY) and the BURST and NQ range-check constants.
REQ-031 A single sub-module, rr_pick, takes req[NQ] and ptr and returns a found flag and an index; it is purely combinational.
REQ-032 The output register and the FSM live in fifo_rr_sched; no storage beyond the single output word.

Verification
REQ-033 Only FIFO 2 non-empty holding 3 words, out_ready=1 -> readout[2] pulses 3 cycles, out_src=2 for 3 words, then IDLE with rr_ptr=3.
REQ-034 All 4 FIFOs holding 10 words each, BURST=4, out_ready=1 -> source sequence 0x4,1x4,2x4,3x4,0x4..., with one bubble between bursts.
REQ-035 FIFO 1 streaming, out_ready low for 5 cycles -> out_valid held, out_data stable, readout zero, burst_cnt unchanged; resumes on release.
REQ-036 FIFO 0 empties after 2 of 4 burst words while FIFO 3 is non-empty -> grant moves to 3 with no readout on empty FIFO 0.
REQ-037 rst_n pulled low mid-burst, and separately softreset for 1 cycle -> all outputs zero next cycle, first grant after release is the lowest non-empty index.
